dual_rail_shift_rows_reg: RTL and testbench
===========================================

Name: dual_rail_shift_rows_reg

Overview:
Registered, parametrised dual-rail (true/false rail) Rijndael ShiftRows/InvShiftRows stage for the hiding-countermeasure AES datapath. It supports NB = 4, 6 or 8 columns and selects forward or inverse mode per token. The stage enforces a mandatory all-zero spacer (precharge) cycle between tokens, uses a valid/ready handshake, and checks the rail encoding of every token it accepts. It sits between SubBytes and MixColumns in the round pipeline.

Parameters:
NB, 4, number of state columns; legal values 4, 6, 8; any other value is an elaboration error.
BYTE, 8, bits per byte.
WORD, 32, bits per column (4 rows x BYTE).
N, WORD*NB, state width; localparam, not overridable.

Ports:
clk  input  1  clock; rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input token present.
in_ready  output  1  stage can accept a token this cycle.
inverse  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the token.
Text_In_T  input  N  true rail of the input state.
Text_In_F  input  N  false rail of the input state.
out_valid  output  1  output token present.
out_ready  input  1  downstream accepts the token.
Out_Text_T  output  N  true rail of the output state (registered).
Out_Text_F  output  N  false rail of the output state (registered).
rail_err  output  1  sticky rail-encoding violation flag.

Behaviour:
- State layout: column c occupies bits [N-1-WORD*c -: WORD]. Row r within a column is at byte offset [WORD-1-BYTE*r -: BYTE] of that column, so byte 0 is at the MSB.
- Row shift offsets s_r: for NB=4 and NB=6, (0,1,2,3); for NB=8, (0,1,3,4).
- Forward mapping: out[r][c] = in[r][(c+s_r) mod NB]. Inverse mapping: out[r][c] = in[r][(c-s_r+NB) mod NB]. The same permutation is applied to both rails.
- FSM has two states: SPACER and HOLD.
- SPACER state:
  - Out_Text_T = Out_Text_F = 0; out_valid = 0; in_ready = 1.
  - If in_valid = 1: the permuted T/F rails are registered and the FSM moves to HOLD. Latency is 1 cycle.
- HOLD state:
  - Outputs carry the registered token; out_valid = 1; in_ready = 0.
  - If out_ready = 1: both output rails are cleared to 0 on the same edge and the FSM returns to SPACER.
  - If out_ready = 0: outputs are held unchanged.
- Throughput is at most one token per 2 cycles. A spacer cycle always separates two tokens.
- in_valid while in_ready = 0 is ignored. The sender must hold the token stable until in_ready = 1.
- Rail check: when a token is accepted, any bit with (T XNOR F) = 1 sets rail_err. Both-rails-0 and both-rails-1 are both violations. The token is still captured unchanged. rail_err stays set until reset.
- Reset (asynchronous, mid-operation included) immediately forces:
  - FSM to SPACER;
  - Out_Text_T = Out_Text_F = 0;
  - out_valid = 0; rail_err = 0;
  - in_ready = 1 after rst_n deasserts.
- No combinational path from in_* to out_*. in_ready depends only on FSM state.

Optional Feature:
DR_RAIL_CHECK_EN
- Defined: the rail check above is implemented.
- Undefined: the check logic is removed and rail_err is tied to 0. Datapath and handshake are unchanged.

Test Plan:
1. NB=4, reset, then token T = 000102030405060708090A0B0C0D0E0F, F = ~T, inverse=0, out_ready=1 → one cycle later out_valid=1 and Out_Text_T = 00050A0F04090E03080D02070C01060B, Out_Text_F = ~Out_Text_T. Next cycle both rails are 0 and out_valid=0.
2. NB=4, T = 00050A0F04090E03080D02070C01060B, F = ~T, inverse=1 → Out_Text_T = 000102030405060708090A0B0C0D0E0F; forward followed by inverse is the identity.
3. NB=8, T = bytes 00..1F ascending, F = ~T, forward → row 2 of column 0 = 0E (column 3) and row 3 of column 0 = 13 (column 4); rail_err stays 0.
4. Backpressure: token accepted with out_ready=0 for 5 cycles → outputs stable, in_ready=0, a second in_valid is ignored. Raising out_ready gives a spacer cycle, then the second token is accepted.
5. DR_RAIL_CHECK_EN defined: token with T[0]=F[0]=1 → rail_err=1 the next cycle and still 1 after 3 clean tokens. With the macro undefined, rail_err stays 0.
6. rst_n pulsed low mid-HOLD → outputs, out_valid and rail_err are 0 before the next clk edge; a new token is accepted on the first edge after release.

Source files
------------

// File: rtl/dual_rail_shift_rows_reg.sv
// Registered dual-rail ShiftRows / InvShiftRows stage for the hiding-countermeasure
// AES round pipeline (between SubBytes and MixColumns).
//
// Tokens are separated by a mandatory all-zero spacer (precharge) cycle. The stage
// accepts a token only in SPACER and holds it in HOLD until downstream takes it.
// Leaving HOLD clears both rails to 0 on the same edge.
//
// Optional feature macro: DR_RAIL_CHECK_EN
//   defined   -> every accepted token is checked for rail-encoding violations
//                (T XNOR F = 1 on any bit). The result is a sticky rail_err.
//   undefined -> the check logic is absent and rail_err is tied to 0.
module dual_rail_shift_rows_reg #(
    parameter int NB   = 4,
    parameter int BYTE = 8,
    parameter int WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 inverse,
    input  logic [WORD*NB-1:0]   Text_In_T,
    input  logic [WORD*NB-1:0]   Text_In_F,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD*NB-1:0]   Out_Text_T,
    output logic [WORD*NB-1:0]   Out_Text_F,
    output logic                 rail_err
);

    localparam int N = WORD * NB;

    // Only 4, 6 and 8 columns are meaningful for Rijndael. Anything else fails elaboration.
    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
        $error("dual_rail_shift_rows_reg: NB must be 4, 6 or 8");
    end

    typedef enum logic {
        SPACER = 1'b0,
        HOLD   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   out_t_q, out_t_d;
    logic [N-1:0]   out_f_q, out_f_d;
    logic [N-1:0]   perm_t;
    logic [N-1:0]   perm_f;
    logic           accept;

    // Byte permutation shared by both rails.
    // Column c is at the MSB end for c = 0, and row 0 is the top byte of each column.
    // Row r of output column c comes from column (c + s_r) mod NB in forward mode.
    // It comes from column (c - s_r) mod NB in inverse mode.
    // For NB = 8, rows 2 and 3 shift one position further.
    function automatic logic [N-1:0] shift_rows(input logic [N-1:0] x, input logic inv);
        logic [N-1:0] y;
        int           s;
        int           src;
        y = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                s   = (NB == 8 && r >= 2) ? r + 1 : r;
                src = inv ? ((c - s + NB) % NB) : ((c + s) % NB);
                y[N-1-WORD*c-BYTE*r -: BYTE] = x[N-1-WORD*src-BYTE*r -: BYTE];
            end
        end
        return y;
    endfunction

    // Permute both input rails identically. The result is only registered on accept.
    always_comb begin
        perm_t = shift_rows(Text_In_T, inverse);
        perm_f = shift_rows(Text_In_F, inverse);
    end

    assign accept = (state_q == SPACER) && in_valid;

    // Next-state and output-register logic for the SPACER/HOLD handshake.
    always_comb begin
        state_d = state_q;
        out_t_d = out_t_q;
        out_f_d = out_f_q;
        case (state_q)
            SPACER: begin
                if (accept) begin
                    state_d = HOLD;
                    out_t_d = perm_t;
                    out_f_d = perm_f;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = SPACER;
                    out_t_d = '0;
                    out_f_d = '0;
                end
            end
            default: begin
                state_d = SPACER;
                out_t_d = '0;
                out_f_d = '0;
            end
        endcase
    end

    // State and data registers. Reset returns the stage to an empty spacer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SPACER;
            out_t_q <= '0;
            out_f_q <= '0;
        end else begin
            state_q <= state_d;
            out_t_q <= out_t_d;
            out_f_q <= out_f_d;
        end
    end

    assign in_ready   = (state_q == SPACER);
    assign out_valid  = (state_q == HOLD);
    assign Out_Text_T = out_t_q;
    assign Out_Text_F = out_f_q;

`ifdef DR_RAIL_CHECK_EN
    logic rail_err_q, rail_err_d;

    // Flag any bit of an accepted token whose rails are equal (00 or 11). The flag is sticky.
    always_comb begin
        rail_err_d = rail_err_q | (accept & (|(~(Text_In_T ^ Text_In_F))));
    end

    // Sticky error register. Only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rail_err_q <= 1'b0;
        end else begin
            rail_err_q <= rail_err_d;
        end
    end

    assign rail_err = rail_err_q;
`else
    assign rail_err = 1'b0;
`endif

endmodule

// File: tb/tb_dual_rail_shift_rows_reg.sv
// Self-checking bench for dual_rail_shift_rows_reg.
// It builds one instance with NB = 4 and one with NB = 8.
// Expected outputs come from a row-rotation model built on byte queues.
module tb_dual_rail_shift_rows_reg;

    logic         clk;
    logic         rst_n;

    logic         in_valid4, in_ready4, inv4, out_valid4, out_ready4, rail_err4;
    logic [127:0] t4, f4, ot4, of4;

    logic         in_valid8, in_ready8, inv8, out_valid8, out_ready8, rail_err8;
    logic [255:0] t8, f8, ot8, of8;

    int           vectors;
    int           miscompares;
    bit           exp_rail4;
    bit           exp_rail8;

    dual_rail_shift_rows_reg #(.NB(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .inverse    (inv4),
        .Text_In_T  (t4),
        .Text_In_F  (f4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .Out_Text_T (ot4),
        .Out_Text_F (of4),
        .rail_err   (rail_err4)
    );

    dual_rail_shift_rows_reg #(.NB(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid8),
        .in_ready   (in_ready8),
        .inverse    (inv8),
        .Text_In_T  (t8),
        .Text_In_F  (f8),
        .out_valid  (out_valid8),
        .out_ready  (out_ready8),
        .Out_Text_T (ot8),
        .Out_Text_F (of8),
        .rail_err   (rail_err8)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: split the state into rows and rotate each row as a queue.
    // A left rotation by s gives the forward mapping; a right rotation gives the inverse.
    function automatic logic [255:0] ref_shift(input logic [255:0] x, input int nb, input bit inv);
        logic [255:0] y;
        logic [7:0]   row[$];
        int           s;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            row.delete();
            for (int c = 0; c < nb; c++) row.push_back(x[nb*32-1-32*c-8*r -: 8]);
            s = (nb == 8 && r >= 2) ? r + 1 : r;
            repeat (s) begin
                if (!inv) row.push_back(row.pop_front());
                else      row.push_front(row.pop_back());
            end
            for (int c = 0; c < nb; c++) y[nb*32-1-32*c-8*r -: 8] = row[c];
        end
        return y;
    endfunction

    function automatic logic [255:0] rand_state(input int nb);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < nb; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] state_mask(input int nb);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < nb*32; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic get_out(input int nb, output logic v, output logic r, output logic e,
                           output logic [255:0] ot, output logic [255:0] of);
        if (nb == 4) begin
            v = out_valid4; r = in_ready4; e = rail_err4;
            ot = {128'b0, ot4}; of = {128'b0, of4};
        end else begin
            v = out_valid8; r = in_ready8; e = rail_err8;
            ot = ot8; of = of8;
        end
    endtask

    // Present one token at a negedge. Hold it for 'stall' extra cycles, then release it.
    // Each held cycle and the spacer cycle that follows are checked.
    task automatic run_token(input int nb, input logic [255:0] t, input logic [255:0] f,
                             input bit inv, input int stall, input bit use_want,
                             input logic [255:0] want_t, input logic [255:0] want_f);
        logic [255:0] exp_t, exp_f, got_t, got_f;
        logic         gv, gr, ge;
        bit           er;
        exp_t = use_want ? want_t : ref_shift(t, nb, inv);
        exp_f = use_want ? want_f : ref_shift(f, nb, inv);
        if (nb == 4) begin
            t4 = t[127:0]; f4 = f[127:0]; inv4 = inv; out_ready4 = 1'b0; in_valid4 = 1'b1;
        end else begin
            t8 = t; f8 = f; inv8 = inv; out_ready8 = 1'b0; in_valid8 = 1'b1;
        end
`ifdef DR_RAIL_CHECK_EN
        for (int i = 0; i < nb*32; i++) begin
            if (t[i] === f[i]) begin
                if (nb == 4) exp_rail4 = 1'b1;
                else         exp_rail8 = 1'b1;
            end
        end
`endif
        @(negedge clk);
        if (nb == 4) in_valid4 = 1'b0;
        else         in_valid8 = 1'b0;
        er = (nb == 4) ? exp_rail4 : exp_rail8;
        for (int k = 0; k <= stall; k++) begin
            get_out(nb, gv, gr, ge, got_t, got_f);
            vectors++;
            if ({gv, gr} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL hold_handshake nb=%0d k=%0d: valid,ready=%b%b want 10", nb, k, gv, gr);
            end
            vectors++;
            if (got_t !== exp_t) begin
                miscompares++;
                $display("[TB] FAIL hold_true nb=%0d k=%0d: got %h want %h", nb, k, got_t, exp_t);
            end
            vectors++;
            if (got_f !== exp_f) begin
                miscompares++;
                $display("[TB] FAIL hold_false nb=%0d k=%0d: got %h want %h", nb, k, got_f, exp_f);
            end
            vectors++;
            if (ge !== er) begin
                miscompares++;
                $display("[TB] FAIL rail_err nb=%0d k=%0d: got %b want %b", nb, k, ge, er);
            end
            if (k == stall) begin
                if (nb == 4) out_ready4 = 1'b1;
                else         out_ready8 = 1'b1;
            end
            @(negedge clk);
        end
        get_out(nb, gv, gr, ge, got_t, got_f);
        vectors++;
        if ({gv, gr} !== 2'b01 || got_t !== '0 || got_f !== '0) begin
            miscompares++;
            $display("[TB] FAIL spacer nb=%0d: valid,ready=%b%b T=%h F=%h want 01 and zero rails",
                     nb, gv, gr, got_t, got_f);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid4 = 1'b0; inv4 = 1'b0; out_ready4 = 1'b0; t4 = '0; f4 = '0;
        in_valid8 = 1'b0; inv8 = 1'b0; out_ready8 = 1'b0; t8 = '0; f8 = '0;
        exp_rail4 = 1'b0; exp_rail8 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({out_valid4, rail_err4, ot4, of4} !== '0 || {out_valid8, rail_err8, ot8, of8} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: v4=%b e4=%b v8=%b e8=%b want all zero",
                     out_valid4, rail_err4, out_valid8, rail_err8);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if ({in_ready4, in_ready8} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b%b want 11", in_ready4, in_ready8);
        end
    endtask

    task automatic test_known_vectors();
        logic [255:0] a, b;
        a = {128'b0, 128'h000102030405060708090A0B0C0D0E0F};
        b = {128'b0, 128'h00050A0F04090E03080D02070C01060B};
        run_token(4, a, a ^ state_mask(4), 1'b0, 0, 1'b1, b, b ^ state_mask(4));
        run_token(4, b, b ^ state_mask(4), 1'b1, 0, 1'b1, a, a ^ state_mask(4));
    endtask

    task automatic test_nb8();
        logic [255:0] t;
        for (int k = 0; k < 32; k++) t[255-8*k -: 8] = 8'(k);
        t8 = t; f8 = ~t; inv8 = 1'b0; out_ready8 = 1'b0; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        vectors++;
        if (ot8[239:232] !== 8'h0E || ot8[231:224] !== 8'h13) begin
            miscompares++;
            $display("[TB] FAIL nb8_col0_rows23: got %h %h want 0e 13", ot8[239:232], ot8[231:224]);
        end
        vectors++;
        if (ot8 !== ref_shift(t, 8, 1'b0) || of8 !== ~ot8 || rail_err8 !== 1'b0 || out_valid8 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL nb8_token: T=%h F=%h v=%b e=%b", ot8, of8, out_valid8, rail_err8);
        end
        out_ready8 = 1'b1;
        @(negedge clk);
        vectors++;
        if (out_valid8 !== 1'b0 || ot8 !== '0 || of8 !== '0) begin
            miscompares++;
            $display("[TB] FAIL nb8_spacer: v=%b T=%h F=%h want zero", out_valid8, ot8, of8);
        end
    endtask

    task automatic test_random();
        logic [255:0] t;
        for (int i = 0; i < 20; i++) begin
            t = rand_state(4);
            run_token(4, t, t ^ state_mask(4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0, '0);
        end
        for (int i = 0; i < 10; i++) begin
            t = rand_state(8);
            run_token(8, t, ~t, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0, '0, '0);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] a, b, ea, eb;
        a = rand_state(4); b = rand_state(4);
        ea = ref_shift(a, 4, 1'b0); eb = ref_shift(b, 4, 1'b1);
        t4 = a[127:0]; f4 = ~a[127:0]; inv4 = 1'b0; out_ready4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        t4 = b[127:0]; f4 = ~b[127:0]; inv4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if ({out_valid4, in_ready4} !== 2'b10 || ot4 !== ea[127:0] || of4 !== ~ea[127:0]) begin
                miscompares++;
                $display("[TB] FAIL backpressure k=%0d: v,r=%b%b T=%h want 10 %h",
                         k, out_valid4, in_ready4, ot4, ea[127:0]);
            end
            @(negedge clk);
        end
        out_ready4 = 1'b1;
        @(negedge clk);
        vectors++;
        if ({out_valid4, in_ready4} !== 2'b01 || ot4 !== '0 || of4 !== '0) begin
            miscompares++;
            $display("[TB] FAIL b2b_spacer: v,r=%b%b T=%h F=%h want 01 zero", out_valid4, in_ready4, ot4, of4);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        vectors++;
        if (out_valid4 !== 1'b1 || ot4 !== eb[127:0] || of4 !== ~eb[127:0]) begin
            miscompares++;
            $display("[TB] FAIL b2b_second: v=%b T=%h want 1 %h", out_valid4, ot4, eb[127:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_rail_err();
        logic [255:0] t, f;
        t = rand_state(4); f = t ^ state_mask(4);
        t[0] = 1'b1; f[0] = 1'b1;
        run_token(4, t, f, 1'b0, 0, 1'b0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            t = rand_state(4);
            run_token(4, t, t ^ state_mask(4), 1'b1, 0, 1'b0, '0, '0);
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [255:0] t;
        t = rand_state(4);
        t4 = t[127:0]; f4 = t[127:0]; inv4 = 1'b0; out_ready4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        vectors++;
        if (out_valid4 !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midhold_pre: out_valid=%b want 1", out_valid4);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_rail4 = 1'b0; exp_rail8 = 1'b0;
        vectors++;
        if ({out_valid4, rail_err4} !== 2'b00 || ot4 !== '0 || of4 !== '0) begin
            miscompares++;
            $display("[TB] FAIL midhold_reset: v=%b e=%b T=%h F=%h want zero", out_valid4, rail_err4, ot4, of4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = rand_state(4);
        run_token(4, t, t ^ state_mask(4), 1'b0, 1, 1'b0, '0, '0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_known_vectors();
        test_nb8();
        test_random();
        test_back_to_back();
        test_rail_err();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
